// File: rtl/integer_attr_scheduler.sv
// Integer attribute capture for one HTML tag: parses x/y/w/h decimal values into slots.
// Optional ATTR_SATURATE_EN: saturate values at the maximum and flag error instead of wrapping.

`ifndef CHAR_BITES
`define CHAR_BITES 8
`endif
`ifndef ATTRIBUTE_VAL_BITES
`define ATTRIBUTE_VAL_BITES 10
`endif

module integer_attr_scheduler (
    input  logic                            clock,
    input  logic                            resetn,
    input  logic [`CHAR_BITES-1:0]          char,
    input  logic                            char_valid,
    output logic                            char_ready,
    output logic [`ATTRIBUTE_VAL_BITES-1:0] out_x,
    output logic [`ATTRIBUTE_VAL_BITES-1:0] out_y,
    output logic [`ATTRIBUTE_VAL_BITES-1:0] out_w,
    output logic [`ATTRIBUTE_VAL_BITES-1:0] out_h,
    output logic [3:0]                      out_mask,
    output logic                            out_err,
    output logic                            out_valid,
    input  logic                            out_ready
);

    localparam int unsigned CW = `CHAR_BITES;
    localparam int unsigned VW = `ATTRIBUTE_VAL_BITES;

    localparam logic [CW-1:0] CH_LT = CW'(8'h3C);
    localparam logic [CW-1:0] CH_GT = CW'(8'h3E);
    localparam logic [CW-1:0] CH_SP = CW'(8'h20);
    localparam logic [CW-1:0] CH_EQ = CW'(8'h3D);
    localparam logic [CW-1:0] CH_DQ = CW'(8'h22);
    localparam logic [CW-1:0] CH_0  = CW'(8'h30);
    localparam logic [CW-1:0] CH_9  = CW'(8'h39);
    localparam logic [CW-1:0] CH_LA = CW'(8'h61);
    localparam logic [CW-1:0] CH_LZ = CW'(8'h7A);
    localparam logic [CW-1:0] CH_UA = CW'(8'h41);
    localparam logic [CW-1:0] CH_UZ = CW'(8'h5A);
    localparam logic [CW-1:0] CH_X  = CW'(8'h78);
    localparam logic [CW-1:0] CH_Y  = CW'(8'h79);
    localparam logic [CW-1:0] CH_W  = CW'(8'h77);
    localparam logic [CW-1:0] CH_H  = CW'(8'h68);

    typedef enum logic [2:0] {IDLE, TAG, ANAME, AVAL, EMIT} state_t;

    state_t          state, state_next;
    logic            accept;
    logic            is_digit, is_letter, is_term, quote_ok;
    logic [CW-1:0]   digit;
    logic            sel_hit;
    logic [1:0]      sel_idx;
    logic [VW-1:0]   acc, acc_next;
    logic            sat_c;
    logic            key_set, key_hit;
    logic [1:0]      key_idx;
    logic            digit_seen, quoted, val_err;
    logic [VW-1:0]   slot [4];
    logic            clear_c, key_clr_c, key_lat_c, val_start_c;
    logic            quote_c, digit_c, bad_c, commit_c;
    logic            ready_next, valid_next;

    assign accept = char_valid && char_ready;

    // Character classification and slot selection
    always_comb begin
        is_digit  = (char >= CH_0) && (char <= CH_9);
        is_letter = ((char >= CH_LA) && (char <= CH_LZ)) || ((char >= CH_UA) && (char <= CH_UZ));
        is_term   = (char == CH_SP) || (char == CH_GT) || (quoted && (char == CH_DQ));
        quote_ok  = (char == CH_DQ) && !quoted && !digit_seen;
        digit     = char - CH_0;
        sel_hit   = 1'b1;
        sel_idx   = 2'd0;
        unique case (char)
            CH_X:    sel_idx = 2'd0;
            CH_Y:    sel_idx = 2'd1;
            CH_W:    sel_idx = 2'd2;
            CH_H:    sel_idx = 2'd3;
            default: sel_hit = 1'b0;
        endcase
    end

`ifdef ATTR_SATURATE_EN
    localparam int unsigned AW = VW + 4;
    logic [AW-1:0] acc_wide;
    always_comb begin
        acc_wide = AW'(acc) * AW'(10) + AW'(digit);
        sat_c    = acc_wide > AW'({VW{1'b1}});
        acc_next = sat_c ? {VW{1'b1}} : acc_wide[VW-1:0];
    end
`else
    always_comb begin
        sat_c    = 1'b0;
        acc_next = acc * VW'(10) + VW'(digit);
    end
`endif

    // State register, plus the handshake flags that follow it
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            char_ready <= 1'b1;
            out_valid  <= 1'b0;
        end else begin
            state      <= state_next;
            char_ready <= ready_next;
            out_valid  <= valid_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:  if (accept && char == CH_LT) state_next = TAG;
            TAG:   if (accept) begin
                       if (char == CH_SP)      state_next = ANAME;
                       else if (char == CH_GT) state_next = EMIT;
                   end
            ANAME: if (accept) begin
                       if (char == CH_EQ)      state_next = AVAL;
                       else if (char == CH_GT) state_next = EMIT;
                   end
            AVAL:  if (accept && is_term) state_next = (char == CH_GT) ? EMIT : ANAME;
            EMIT:  if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath control strobes and next handshake flags
    always_comb begin
        clear_c     = accept && (state == IDLE) && (char == CH_LT);
        key_clr_c   = accept && (state == ANAME) && (char == CH_SP);
        key_lat_c   = accept && (state == ANAME) && is_letter && !key_set;
        val_start_c = accept && (state == ANAME) && (char == CH_EQ);
        quote_c     = accept && (state == AVAL) && !is_term && quote_ok;
        digit_c     = accept && (state == AVAL) && is_digit;
        bad_c       = accept && (state == AVAL) && !is_term && !is_digit && !quote_ok;
        commit_c    = accept && (state == AVAL) && is_term;
        ready_next  = (state_next != EMIT);
        valid_next  = (state_next == EMIT);
    end

    // Slot, key and accumulator registers
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < 4; i++) slot[i] <= '0;
            out_mask   <= '0;
            out_err    <= 1'b0;
            key_set    <= 1'b0;
            key_hit    <= 1'b0;
            key_idx    <= 2'd0;
            acc        <= '0;
            digit_seen <= 1'b0;
            quoted     <= 1'b0;
            val_err    <= 1'b0;
        end else begin
            if (clear_c) begin
                for (int i = 0; i < 4; i++) slot[i] <= '0;
                out_mask   <= '0;
                out_err    <= 1'b0;
                key_set    <= 1'b0;
                key_hit    <= 1'b0;
                key_idx    <= 2'd0;
                acc        <= '0;
                digit_seen <= 1'b0;
                quoted     <= 1'b0;
                val_err    <= 1'b0;
            end
            if (key_clr_c) begin
                key_set <= 1'b0;
                key_hit <= 1'b0;
            end
            if (key_lat_c) begin
                key_set <= 1'b1;
                key_hit <= sel_hit;
                key_idx <= sel_idx;
            end
            if (val_start_c) begin
                acc        <= '0;
                digit_seen <= 1'b0;
                quoted     <= 1'b0;
                val_err    <= 1'b0;
            end
            if (quote_c) quoted <= 1'b1;
            if (digit_c) begin
                acc        <= acc_next;
                digit_seen <= 1'b1;
                if (sat_c) out_err <= 1'b1;
            end
            if (bad_c) begin
                val_err <= 1'b1;
                out_err <= 1'b1;
            end
            // Key is released on commit so the next name can latch its first letter
            if (commit_c) begin
                if (key_hit && digit_seen && !val_err) begin
                    slot[key_idx]     <= acc;
                    out_mask[key_idx] <= 1'b1;
                end
                key_set <= 1'b0;
                key_hit <= 1'b0;
            end
        end
    end

    assign out_x = slot[0];
    assign out_y = slot[1];
    assign out_w = slot[2];
    assign out_h = slot[3];

endmodule

// File: tb/tb_integer_attr_scheduler.sv
// Directed bench for integer_attr_scheduler; expected values hand-computed from tag strings.

module tb_integer_attr_scheduler;

    logic       clock = 1'b0;
    logic       resetn;
    logic [7:0] char;
    logic       char_valid;
    logic       char_ready;
    logic [9:0] out_x, out_y, out_w, out_h;
    logic [3:0] out_mask;
    logic       out_err;
    logic       out_valid;
    logic       out_ready;

    int checks   = 0;
    int failures = 0;

    integer_attr_scheduler dut (
        .clock      (clock),
        .resetn     (resetn),
        .char       (char),
        .char_valid (char_valid),
        .char_ready (char_ready),
        .out_x      (out_x),
        .out_y      (out_y),
        .out_w      (out_w),
        .out_h      (out_h),
        .out_mask   (out_mask),
        .out_err    (out_err),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drive each char from a falling edge; it is accepted on the next rising edge with ready
    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) begin
            int n;
            @(negedge clock);
            char       = s[i];
            char_valid = 1'b1;
            n = 0;
            while (!char_ready && n < 20) begin
                @(negedge clock);
                n++;
            end
            if (!char_ready) begin
                checks++;
                failures++;
                $display("FAIL send_timeout observed=ready0 expected=ready1");
            end
            @(posedge clock);
        end
        @(negedge clock);
        char_valid = 1'b0;
    endtask

    task automatic take(input string tag);
        out_ready = 1'b1;
        @(negedge clock);
        out_ready = 1'b0;
        chk({tag, "_valid_drop"}, 32'(out_valid), 0);
        chk({tag, "_ready_back"}, 32'(char_ready), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn     = 1'b0;
        char       = 8'h00;
        char_valid = 1'b0;
        out_ready  = 1'b0;
        repeat (3) @(negedge clock);
        chk("rst_ready", 32'(char_ready), 1);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_mask",  32'(out_mask), 0);
        chk("rst_err",   32'(out_err), 0);
        chk("rst_x",     32'(out_x), 0);
        resetn = 1'b1;

        // Stall cycles mid-value, quoted value, latency of out_valid
        send_str("<img x=1");
        repeat (3) @(negedge clock);
        send_str("2 y=\"340\"");
        chk("t1_not_yet_valid", 32'(out_valid), 0);
        send_str(">");
        chk("t1_valid", 32'(out_valid), 1);
        chk("t1_ready_low", 32'(char_ready), 0);
        chk("t1_x", 32'(out_x), 12);
        chk("t1_y", 32'(out_y), 340);
        chk("t1_mask", 32'(out_mask), 4'b0011);
        chk("t1_err", 32'(out_err), 0);
        take("t1");

        // Duplicate key last-wins, zero still written
        send_str("<r w=5 w=7 h=0>");
        chk("t2_valid", 32'(out_valid), 1);
        chk("t2_w", 32'(out_w), 7);
        chk("t2_h", 32'(out_h), 0);
        chk("t2_x", 32'(out_x), 0);
        chk("t2_mask", 32'(out_mask), 4'b1100);
        chk("t2_err", 32'(out_err), 0);
        take("t2");

        // Malformed value discarded, error flagged
        send_str("<r x=1a2 y=3>");
        chk("t3_err", 32'(out_err), 1);
        chk("t3_x", 32'(out_x), 0);
        chk("t3_y", 32'(out_y), 3);
        chk("t3_mask", 32'(out_mask), 4'b0010);
        take("t3");

        // Overflow
        send_str("<r x=2000>");
`ifdef ATTR_SATURATE_EN
        chk("t4_x", 32'(out_x), 1023);
        chk("t4_err", 32'(out_err), 1);
`else
        chk("t4_x", 32'(out_x), 976);
        chk("t4_err", 32'(out_err), 0);
`endif
        chk("t4_mask", 32'(out_mask), 4'b0001);
        take("t4");

        // Uppercase key selects nothing; only the first letter of a name matters
        send_str("<r X=4 xy=5>");
        chk("t5_x", 32'(out_x), 5);
        chk("t5_mask", 32'(out_mask), 4'b0001);
        chk("t5_err", 32'(out_err), 0);
        take("t5");

        // Backpressure: hold consumer off while a '<' is offered
        send_str("<r h=1>");
        char       = 8'h3C;
        char_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            chk("bp_ready_low", 32'(char_ready), 0);
            chk("bp_valid_high", 32'(out_valid), 1);
            chk("bp_h_stable", 32'(out_h), 1);
            chk("bp_mask_stable", 32'(out_mask), 4'b1000);
        end
        out_ready = 1'b1;
        @(negedge clock);
        out_ready = 1'b0;
        chk("bp_idle_ready", 32'(char_ready), 1);
        chk("bp_idle_valid", 32'(out_valid), 0);
        chk("bp_idle_h_held", 32'(out_h), 1);
        @(negedge clock);
        char_valid = 1'b0;
        chk("bp_lt_cleared_h", 32'(out_h), 0);
        chk("bp_lt_cleared_mask", 32'(out_mask), 0);
        send_str("r>");
        chk("bp_empty_valid", 32'(out_valid), 1);
        chk("bp_empty_mask", 32'(out_mask), 0);
        take("bp");

        // Reset mid-value discards the partial tag
        send_str("<r x=45");
        #2 resetn = 1'b0;
        #1;
        chk("mid_rst_ready", 32'(char_ready), 1);
        chk("mid_rst_valid", 32'(out_valid), 0);
        @(negedge clock);
        resetn = 1'b1;
        send_str("<r y=9>");
        chk("t6_valid", 32'(out_valid), 1);
        chk("t6_x", 32'(out_x), 0);
        chk("t6_y", 32'(out_y), 9);
        chk("t6_mask", 32'(out_mask), 4'b0010);
        chk("t6_err", 32'(out_err), 0);

        // Reset while presenting a result clears everything
        #2 resetn = 1'b0;
        #1;
        chk("emit_rst_valid", 32'(out_valid), 0);
        chk("emit_rst_ready", 32'(char_ready), 1);
        chk("emit_rst_y", 32'(out_y), 0);
        chk("emit_rst_mask", 32'(out_mask), 0);
        @(negedge clock);
        resetn = 1'b1;
        @(negedge clock);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/integer_attr_scheduler.md
# integer_attr_scheduler

Sequences integer attribute capture for one HTML tag at a time: consumes the character stream with a valid/ready handshake, finds `x`, `y`, `w` and `h` attributes, and accumulates their decimal values into four slots. When the tag closes it presents all slots, a presence mask and an error flag as one result. Sits between the character source and the layout/render stage and replaces ad-hoc `state_enable` sequencing of per-attribute integer parsing.

## Interface
Parameters:
- none; widths come from the global macros `CHAR_BITES` (8 bits) and `ATTRIBUTE_VAL_BITES` (10 bits).

Ports:
- clock  in  1  single clock, rising edge
- resetn  in  1  asynchronous, active-low reset
- char  in  `CHAR_BITES`  ASCII character
- char_valid  in  1  char is valid this cycle
- char_ready  out  1  block accepts char this cycle
- out_x, out_y, out_w, out_h  out  `ATTRIBUTE_VAL_BITES` each  slot values
- out_mask  out  4  slot written flags, bit0=x, bit1=y, bit2=w, bit3=h
- out_err  out  1  malformed value seen in this tag
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result

## Operation
- A char is accepted on a rising edge when char_valid && char_ready. char_ready = (state != EMIT).
- States and transitions on an accepted char:
  - IDLE: '<' -> TAG, clears slots, mask, err, key, accumulator. Anything else is dropped.
  - TAG: ' ' -> ANAME; '>' -> EMIT; all other chars are ignored (tag name).
  - ANAME: ' ' is skipped and clears the key. The first letter of a name latches the key: 'x','y','w','h' (lowercase only) select a slot; any other letter selects none. Later letters are ignored. '=' -> AVAL with accumulator=0, digit count=0, quoted=0. '>' -> EMIT.
  - AVAL: a leading '"' (before any digit) sets quoted. A digit '0'-'9' sets acc = acc*10 + digit, truncated to 10 bits (see Configuration), and increments the digit count. A terminator is ' ', '>' or '"' when quoted; it commits the value and then goes to ANAME (' ' or '"') or EMIT ('>'). Any other char sets out_err and the value is discarded; parsing continues until the terminator.
- Commit: the slot is written and its mask bit set only if the key selects a slot, at least one digit was seen, and no error occurred in this value. A duplicate key is last-write-wins.
- EMIT: out_valid=1 and outputs hold stable. When out_ready is high, the next state is IDLE and out_valid drops.
- Outputs are registered. out_* values are held from the last tag until the next '<' clears them.

## Timing
- Reset (async assert, any state): state=IDLE, all slots=0, out_mask=0, out_err=0, out_valid=0, and therefore char_ready=1. A partial tag is discarded.
- Throughput: 1 char/cycle outside EMIT.
- Latency: '>' accepted at edge N -> out_valid=1 after edge N. The final value is already committed at that edge.
- Backpressure: char_ready=0 for every cycle out_valid=1. Handshake completes on the edge with out_valid && out_ready. char_ready returns to 1 after that edge.
- out_ready asserted before out_valid has no effect.
- char_valid=0 cycles stall all state with no change.

## Configuration
- ATTR_SATURATE_EN defined: the accumulator saturates at 1023. Any digit that would exceed 1023 leaves acc at 1023 and sets out_err; the value is still committed.
- ATTR_SATURATE_EN undefined: the accumulator wraps modulo 1024, with no error.

## Test plan
- `<img x=12 y="340">` -> out_x=12, out_y=340, out_mask=0011, out_err=0, out_valid one cycle after '>' is accepted.
- `<r w=5 w=7 h=0>` -> out_w=7, out_h=0, out_mask=1100 (duplicate last-wins, zero is still written).
- `<r x=1a2 y=3>` -> out_err=1, x not written, out_y=3, out_mask=0010.
- `<r x=2000>` -> with ATTR_SATURATE_EN: out_x=1023, out_err=1. Without it: out_x=976, out_err=0.
- Hold out_ready=0 for 5 cycles while char_valid=1: char_ready=0 and outputs stable throughout. Then out_ready=1 for one cycle: the next edge goes to IDLE and the following '<' is accepted.
- Assert resetn=0 mid-value in `<r x=45`, release, then send `<r y=9>` -> out_x=0, out_y=9, out_mask=0010.
